// File: rtl/sd_read_bench.sv
// rtl/sd_read_bench.sv - SD block-read throughput unit driven by the autotest harness
//
// Reads n_blocks consecutive 512-byte blocks from the sdspi host, using either
// repeated single-block reads or one multi-block (CMD18) read, sums every byte
// into a 32-bit checksum and raises finish when done or when the host errors.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_start                 level start from the harness
//   i_n_blocks              blocks to read (latched on start)
//   i_sclk_speed            SPI divider select (latched, forwarded on o_spi_sclk_speed)
//   i_cmd18                 1 = multi-block read, 0 = single-block reads (latched)
//   o_finish, o_err         completion / host-error flags, held until reset
//   o_checksum              modulo-2^32 sum of bytes read
//   o_blocks_done           fully read blocks
//   i_spi_busy, i_spi_data_out, i_spi_err, i_spi_crc_err   host status and data
//   o_spi_block_addr, o_spi_r_block, o_spi_r_multi_block, o_spi_r_byte,
//   o_spi_sclk_speed        host requests
module sd_read_bench #(
  parameter logic [31:0] START_BLOCK     = 32'h00100000,
  parameter int          N_BLOCK_SIZE    = 32,
  parameter int          SCLK_SPEED_SIZE = 5,
  parameter int          BLOCK_BYTES     = 512
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [N_BLOCK_SIZE-1:0]    i_n_blocks,
  input  logic [SCLK_SPEED_SIZE-1:0] i_sclk_speed,
  input  logic                       i_cmd18,
  output logic                       o_finish,
  output logic                       o_err,
  output logic [31:0]                o_checksum,
  output logic [N_BLOCK_SIZE-1:0]    o_blocks_done,
  input  logic                       i_spi_busy,
  input  logic [7:0]                 i_spi_data_out,
  input  logic                       i_spi_err,
  input  logic                       i_spi_crc_err,
  output logic [31:0]                o_spi_block_addr,
  output logic                       o_spi_r_block,
  output logic                       o_spi_r_multi_block,
  output logic                       o_spi_r_byte,
  output logic [SCLK_SPEED_SIZE-1:0] o_spi_sclk_speed
);

  localparam int                    BYTE_CNT_W = $clog2(BLOCK_BYTES);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE  = BYTE_CNT_W'(BLOCK_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SEL_BLOCK, S_WAIT_BLOCK, S_REQ_BYTE, S_WAIT_BYTE,
    S_END_BLOCK, S_STOP, S_DONE, S_ERROR
  } state_t;

  state_t                       r_state;
  logic [N_BLOCK_SIZE-1:0]      r_n_blocks;
  logic                         r_cmd18;
  logic [BYTE_CNT_W-1:0]        r_byte_cnt;
  logic                         r_stop_low;
  logic                         r_finish;
  logic                         r_err;
  logic [31:0]                  r_checksum;
  logic [N_BLOCK_SIZE-1:0]      r_blocks_done;
  logic [31:0]                  r_block_addr;
  logic                         r_r_block;
  logic                         r_r_multi;
  logic                         r_r_byte;
  logic [SCLK_SPEED_SIZE-1:0]   r_sclk_speed;

  logic                         w_host_err;
  logic [N_BLOCK_SIZE-1:0]      w_blocks_next;

  assign w_host_err    = i_spi_err | i_spi_crc_err;
  assign w_blocks_next = r_blocks_done + N_BLOCK_SIZE'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_n_blocks    <= '0;
      r_cmd18       <= 1'b0;
      r_byte_cnt    <= '0;
      r_stop_low    <= 1'b0;
      r_finish      <= 1'b0;
      r_err         <= 1'b0;
      r_checksum    <= '0;
      r_blocks_done <= '0;
      r_block_addr  <= '0;
      r_r_block     <= 1'b0;
      r_r_multi     <= 1'b0;
      r_r_byte      <= 1'b0;
      r_sclk_speed  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_n_blocks   <= i_n_blocks;
            r_cmd18      <= i_cmd18;
            r_sclk_speed <= i_sclk_speed;
            r_block_addr <= START_BLOCK;
            if (i_n_blocks == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state   <= S_SEL_BLOCK;
              r_r_block <= ~i_cmd18;
              r_r_multi <= i_cmd18;
            end
          end
        end
        S_SEL_BLOCK: begin
          if (i_spi_busy) r_state <= S_WAIT_BLOCK;
        end
        S_WAIT_BLOCK: begin
          if (w_host_err) begin
            r_state   <= S_ERROR;
            r_r_block <= 1'b0;
            r_r_multi <= 1'b0;
            r_r_byte  <= 1'b0;
          end else if (!i_spi_busy) begin
            r_state  <= S_REQ_BYTE;
            r_r_byte <= 1'b1;
          end
        end
        S_REQ_BYTE: begin
          if (i_spi_busy) begin
            r_state  <= S_WAIT_BYTE;
            r_r_byte <= 1'b0;
          end
        end
        S_WAIT_BYTE: begin
          // An error in the same cycle as the busy fall discards the byte.
          if (w_host_err) begin
            r_state   <= S_ERROR;
            r_r_block <= 1'b0;
            r_r_multi <= 1'b0;
            r_r_byte  <= 1'b0;
          end else if (!i_spi_busy) begin
            r_checksum <= r_checksum + {24'd0, i_spi_data_out};
            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
            if (r_byte_cnt == LAST_BYTE) begin
              r_state   <= S_END_BLOCK;
              // single reads release the request for one cycle between blocks
              r_r_block <= 1'b0;
            end else begin
              r_state  <= S_REQ_BYTE;
              r_r_byte <= 1'b1;
            end
          end
        end
        S_END_BLOCK: begin
          r_blocks_done <= w_blocks_next;
          r_byte_cnt    <= '0;
          if (w_blocks_next == r_n_blocks) begin
            r_state    <= S_STOP;
            r_r_block  <= 1'b0;
            r_r_multi  <= 1'b0;
            r_stop_low <= 1'b0;
          end else if (!r_cmd18) begin
            r_state      <= S_SEL_BLOCK;
            r_r_block    <= 1'b1;
            r_block_addr <= START_BLOCK + 32'(w_blocks_next);
          end else begin
            // multi read: the host's busy period now covers the next data token
            r_state <= S_WAIT_BLOCK;
          end
        end
        S_STOP: begin
          // Busy must be seen low on two consecutive cycles so the host has a
          // cycle to start CMD12 after the multi request drops.
          if (w_host_err) begin
            r_state <= S_ERROR;
          end else if (!i_spi_busy) begin
            if (r_stop_low) r_state <= S_DONE;
            r_stop_low <= 1'b1;
          end else begin
            r_stop_low <= 1'b0;
          end
        end
        S_DONE: begin
          r_finish <= 1'b1;
        end
        S_ERROR: begin
          r_finish <= 1'b1;
          r_err    <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_finish            = r_finish;
  assign o_err               = r_err;
  assign o_checksum          = r_checksum;
  assign o_blocks_done       = r_blocks_done;
  assign o_spi_block_addr    = r_block_addr;
  assign o_spi_r_block       = r_r_block;
  assign o_spi_r_multi_block = r_r_multi;
  assign o_spi_r_byte        = r_r_byte;
  assign o_spi_sclk_speed    = r_sclk_speed;

endmodule

// File: doc/sd_read_bench.md
Name: sd_read_bench

Overview:
- Unit-under-test for the SD autotest harness. It sits directly downstream of the autotest FSM, which supplies n_blocks, sclk_speed, cmd18 and start, and reads back finish.
- When the harness hands over the SPI mux, this block reads n_blocks consecutive 512-byte blocks from the sdspi host.
- Reads use either per-block single reads or one multi-block (CMD18) read.
- It accumulates a byte checksum and raises finish, so the harness timer measures raw read throughput.

Parameters:
START_BLOCK, 32'h00100000, first SD block address read.
N_BLOCK_SIZE, 32, width of block-count input and counters.
SCLK_SPEED_SIZE, 5, width of SPI clock divider select.
BLOCK_BYTES, 512, bytes per SD block.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset (harness drives it from uut_rst)
start  in  1  level; held high by harness for whole test
n_blocks  in  N_BLOCK_SIZE  blocks to read
sclk_speed  in  SCLK_SPEED_SIZE  divider select forwarded to host
cmd18  in  1  1 = multi-block read, 0 = repeated single-block reads
finish  out  1  test complete (success or error), held until rst
err  out  1  host reported spi_err/spi_crc_err
checksum  out  32  modulo-2^32 sum of all bytes read
blocks_done  out  N_BLOCK_SIZE  fully read blocks
spi_busy  in  1  host busy
spi_data_out  in  8  byte from host, valid when busy falls after r_byte
spi_err  in  1  host command/token error
spi_crc_err  in  1  host CRC error
spi_block_addr  out  32  START_BLOCK + blocks_done (single) / START_BLOCK (multi)
spi_r_block  out  1  single-block read request, held for whole block
spi_r_multi_block  out  1  multi-block read request, held for whole transfer
spi_r_byte  out  1  byte request
spi_sclk_speed  out  SCLK_SPEED_SIZE  registered copy of sclk_speed

Behaviour:
- Reset (async): state IDLE; finish=0, err=0, checksum=0, blocks_done=0, byte counter=0, all spi_* requests 0, spi_sclk_speed=0.
- IDLE: when start=1, latch n_blocks, cmd18 and sclk_speed into internal registers.
  - If latched n_blocks==0, go to DONE.
  - Otherwise go to SEL_BLOCK.
  - Input changes after this latch are ignored.
- SEL_BLOCK:
  - Assert spi_r_block (cmd18=0) or spi_r_multi_block (cmd18=1).
  - On spi_busy=1, go to WAIT_BLOCK.
- WAIT_BLOCK: keep request high. On spi_busy=0, go to REQ_BYTE.
- REQ_BYTE: request + spi_r_byte=1. On spi_busy=1, go to WAIT_BYTE.
- WAIT_BYTE: request held, spi_r_byte=0. On spi_busy=0:
  - checksum += zero-extended spi_data_out; byte counter +1.
  - If counter reaches BLOCK_BYTES-1 → END_BLOCK, else → REQ_BYTE.
- END_BLOCK: blocks_done +1, byte counter clears.
  - blocks_done+1 == latched n_blocks → STOP.
  - cmd18=0 → drop spi_r_block for one cycle, then SEL_BLOCK with the new address.
  - cmd18=1 → WAIT_BLOCK with spi_r_multi_block still high; the host busy period covers the next data token.
- STOP:
  - Deassert all requests; in multi mode the host issues CMD12.
  - Wait for spi_busy=0 sustained 1 cycle, then DONE.
- DONE: finish=1, all requests 0, stays until rst. start falling has no effect.
- Error: in WAIT_BLOCK/WAIT_BYTE/STOP, spi_err|spi_crc_err=1 → ERROR.
  - Requests drop the same cycle; err=1, finish=1 the next cycle.
  - Error wins over a simultaneous busy fall (the byte is not accumulated).
- Latency: finish rises exactly 1 cycle after entering DONE/ERROR.
- Counters:
  - blocks_done never exceeds the latched n_blocks.
  - checksum wraps silently.
  - The byte counter is log2(BLOCK_BYTES) wide.
  - spi_block_addr add is 32-bit with wrap.
- rst mid-transfer: everything returns to reset values immediately, requests drop asynchronously.
- start low before IDLE latch: stay IDLE.

Test Plan:
- n_blocks=1, cmd18=0, host model returns bytes 0..255,0..255 → one r_block at addr 0x00100000, 512 r_byte pulses, checksum=0x0000FF00, blocks_done=1, finish=1, err=0.
- n_blocks=3, cmd18=0, bytes all 0x01 → r_block at 0x00100000, 0x00100001, 0x00100002 with 1-cycle gap between; checksum=0x600; blocks_done=3.
- n_blocks=3, cmd18=1, bytes all 0xFF → single continuous r_multi_block at 0x00100000, r_block never high, checksum=0x5FA00, STOP waits for busy low before finish.
- n_blocks=0, start=1 → finish=1 within 3 cycles, no spi request ever asserted, checksum=0.
- spi_crc_err pulsed during WAIT_BYTE of byte 100 in block 2 of 4 → requests drop same cycle, err=1, finish=1, blocks_done=1, checksum excludes that byte.
- rst asserted mid-block (byte 300) then released with start=1, n_blocks=1 → all outputs 0 during rst, full clean 512-byte read afterwards, blocks_done=1.
